// File: rtl/fp_encoder_seq.sv
// rtl/fp_encoder_seq.sv - iterative signed-sample to {sign, exponent, significand} encoder (optional FP_ENCODER_ROUND_EN)
module fp_encoder_seq #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int SIG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [SIG_W-1:0] out_sig,
    output logic             out_sat
);

    localparam int E_MAX = (1 << EXP_W) - 1;
    localparam int MAG_W = IN_W - 1;
    localparam logic [EXP_W-1:0] E_MAX_V = EXP_W'(E_MAX);

    generate
        if (IN_W != SIG_W + E_MAX + 1) begin : g_cfg_err
            $error("fp_encoder_seq: IN_W must equal SIG_W + 2**EXP_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [IN_W-1:0]  data_q;
    logic [MAG_W-1:0] mag_q;
    logic [EXP_W-1:0] lz_q;
    logic             sign_q;
    logic             sat_q;

    logic [IN_W-1:0]  neg_data;
    logic             most_neg;
    logic             norm_step;
    logic [EXP_W-1:0] e_code;
    logic [SIG_W-1:0] f_code;
    logic             sat_code;

    assign neg_data = IN_W'(0) - data_q;
    assign most_neg = (data_q == {1'b1, {(IN_W-1){1'b0}}});
    assign norm_step = !mag_q[MAG_W-1] && (lz_q != E_MAX_V);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CONV;
            end
            CONV:  state_next = NORM;
            NORM:  if (!norm_step) state_next = ROUND;
            ROUND: state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Final code from the normalised magnitude; E = 0 is the exact subnormal range.
`ifdef FP_ENCODER_ROUND_EN
    logic             guard;
    logic [SIG_W:0]   f_inc;
    always_comb begin
        e_code   = E_MAX_V - lz_q;
        f_code   = mag_q[MAG_W-1 -: SIG_W];
        sat_code = sat_q;
        guard    = mag_q[MAG_W-1-SIG_W];
        f_inc    = {1'b0, mag_q[MAG_W-1 -: SIG_W]} + {{SIG_W{1'b0}}, 1'b1};
        if (guard && (e_code != '0)) begin
            if (f_inc[SIG_W]) begin
                if (e_code != E_MAX_V) begin
                    f_code = {1'b1, {(SIG_W-1){1'b0}}};
                    e_code = e_code + 1'b1;
                end else begin
                    f_code   = '1;
                    sat_code = 1'b1;
                end
            end else begin
                f_code = f_inc[SIG_W-1:0];
            end
        end
    end
`else
    always_comb begin
        e_code   = E_MAX_V - lz_q;
        f_code   = mag_q[MAG_W-1 -: SIG_W];
        sat_code = sat_q;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            mag_q    <= '0;
            lz_q     <= '0;
            sign_q   <= 1'b0;
            sat_q    <= 1'b0;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_sig  <= '0;
            out_sat  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (in_valid) data_q <= in_data;
                CONV: begin
                    sign_q <= data_q[IN_W-1];
                    lz_q   <= '0;
                    if (most_neg) begin
                        mag_q <= '1;
                        sat_q <= 1'b1;
                    end else begin
                        mag_q <= data_q[IN_W-1] ? neg_data[MAG_W-1:0] : data_q[MAG_W-1:0];
                        sat_q <= 1'b0;
                    end
                end
                NORM: if (norm_step) begin
                    mag_q <= {mag_q[MAG_W-2:0], 1'b0};
                    lz_q  <= lz_q + 1'b1;
                end
                ROUND: begin
                    out_sign <= sign_q;
                    out_exp  <= e_code;
                    out_sig  <= f_code;
                    out_sat  <= sat_code;
                end
                default: ;
            endcase
        end
    end

endmodule
